// File: rtl/servo_pwm_axil_regs_if.sv
// AXI4-Lite bus bundle for the servo PWM register block.
// The master modport drives requests; the slave modport answers them.
interface servo_pwm_axil_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR;
    logic [2:0]                        AWPROT;
    logic                              AWVALID;
    logic                              AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB;
    logic                              WVALID;
    logic                              WREADY;
    logic [1:0]                        BRESP;
    logic                              BVALID;
    logic                              BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR;
    logic [2:0]                        ARPROT;
    logic                              ARVALID;
    logic                              ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                        RRESP;
    logic                              RVALID;
    logic                              RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/servo_pwm_axil_regs.sv
// AXI4-Lite register block (CTRL, PERIOD, PULSE0, PULSE1) driving servo PWM outputs.
// Period and pulse values go through shadows that reload only at period wrap.
//
// state   | meaning
// W_IDLE  | waiting for AW+W together; AWREADY/WREADY pulse, write on the next edge
// W_RESP  | BVALID held until BREADY
// R_IDLE  | waiting for ARVALID; ARREADY pulses with RDATA captured
// R_DATA  | RVALID/RDATA held until RREADY
module servo_pwm_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_NUM_CH           = 2
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    servo_pwm_axil_regs_if.slave     S_AXI,
    output logic [C_NUM_CH-1:0]      PWM_OUT
);
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    wr_state_t                     wr_state;
    rd_state_t                     rd_state;
    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    logic [1:0]                    wr_idx;
    logic [1:0]                    rd_idx;
    logic [31:0]                   cnt;
    logic [31:0]                   period_sh;
    logic [31:0]                   pulse_sh [C_NUM_CH];
    logic                          pwm_active;
    logic                          unused_ok;

    assign wr_idx      = S_AXI.AWADDR[3:2];
    assign rd_idx      = S_AXI.ARADDR[3:2];
    assign S_AXI.BRESP = 2'b00;
    assign S_AXI.RRESP = 2'b00;
    assign unused_ok   = ^{S_AXI.AWPROT, S_AXI.ARPROT, S_AXI.AWADDR[1:0], S_AXI.ARADDR[1:0]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state      <= W_IDLE;
            S_AXI.AWREADY <= 1'b0;
            S_AXI.WREADY  <= 1'b0;
            S_AXI.BVALID  <= 1'b0;
            for (int r = 0; r < 4; r++) regs[r] <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (S_AXI.AWREADY) begin
                        S_AXI.AWREADY <= 1'b0;
                        S_AXI.WREADY  <= 1'b0;
                        if (S_AXI.AWVALID && S_AXI.WVALID) begin
                            for (int k = 0; k < C_S_AXI_DATA_WIDTH/8; k++)
                                if (S_AXI.WSTRB[k])
                                    regs[wr_idx][8*k +: 8] <= S_AXI.WDATA[8*k +: 8];
                            S_AXI.BVALID <= 1'b1;
                            wr_state     <= W_RESP;
                        end
                    end else if (S_AXI.AWVALID && S_AXI.WVALID) begin
                        S_AXI.AWREADY <= 1'b1;
                        S_AXI.WREADY  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (S_AXI.BREADY) begin
                        S_AXI.BVALID <= 1'b0;
                        wr_state     <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // RDATA is captured as ARREADY rises, so a write landing on the same edge reads old data.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state      <= R_IDLE;
            S_AXI.ARREADY <= 1'b0;
            S_AXI.RVALID  <= 1'b0;
            S_AXI.RDATA   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (S_AXI.ARREADY) begin
                        S_AXI.ARREADY <= 1'b0;
                        if (S_AXI.ARVALID) begin
                            S_AXI.RVALID <= 1'b1;
                            rd_state     <= R_DATA;
                        end
                    end else if (S_AXI.ARVALID && !S_AXI.RVALID) begin
                        S_AXI.ARREADY <= 1'b1;
                        S_AXI.RDATA   <= regs[rd_idx];
                    end
                end
                R_DATA: begin
                    if (S_AXI.RREADY) begin
                        S_AXI.RVALID <= 1'b0;
                        rd_state     <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign pwm_active = regs[0][0] && (period_sh != 32'd0);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt       <= '0;
            period_sh <= '0;
            PWM_OUT   <= '0;
            for (int i = 0; i < C_NUM_CH; i++) pulse_sh[i] <= '0;
        end else if (!pwm_active) begin
            cnt       <= '0;
            PWM_OUT   <= '0;
            period_sh <= regs[1];
            for (int i = 0; i < C_NUM_CH; i++) pulse_sh[i] <= regs[2'(2 + i)];
        end else begin
            if (cnt == period_sh - 32'd1) begin
                cnt       <= '0;
                period_sh <= regs[1];
                for (int i = 0; i < C_NUM_CH; i++) pulse_sh[i] <= regs[2'(2 + i)];
            end else begin
                cnt <= cnt + 32'd1;
            end
            for (int i = 0; i < C_NUM_CH; i++) PWM_OUT[i] <= (cnt < pulse_sh[i]);
        end
    end
endmodule
